// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash read sequencer and its byte-transfer helper.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    HOLD
  } flash_state_t;

  typedef enum logic [1:0] {
    XFER_IDLE,
    XFER_LOAD,
    XFER_SKIP,
    XFER_WAIT
  } xfer_state_t;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] FLASH_DUMMY_BYTE    = 8'h00;

  // Address bytes go out MSB first: index 0 is addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
    case (idx)
      2'd0:    return a[23:16];
      2'd1:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_reader_xfer.sv
// Single-byte handshake with the SPI byte controller: load strobe, one-cycle latency skip,
// then wait for the controller busy flag to clear and capture the received byte.
module spi_byte_xfer
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [7:0]  byte_in,
  input  logic [15:0] spi_out,
  output logic        spi_load,
  output logic [15:0] spi_in,
  output logic        xfer_done,
  output logic [7:0]  rx_byte
);

  xfer_state_t state;
  logic        unused_status;

  assign unused_status = ^spi_out[14:8];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= XFER_IDLE;
      spi_load  <= 1'b0;
      spi_in    <= '0;
      xfer_done <= 1'b0;
      rx_byte   <= '0;
    end else begin
      spi_load  <= 1'b0;
      xfer_done <= 1'b0;
      case (state)
        XFER_IDLE: begin
          if (go) begin
            spi_load <= 1'b1;
            spi_in   <= {8'h00, byte_in};
            state    <= XFER_LOAD;
          end
        end
        XFER_LOAD: state <= XFER_SKIP;
        // The controller raises busy one cycle late, so its flag is meaningless here.
        XFER_SKIP: state <= XFER_WAIT;
        XFER_WAIT: begin
          if (!spi_out[15]) begin
            xfer_done <= 1'b1;
            rx_byte   <= spi_out[7:0];
            state     <= XFER_IDLE;
          end
        end
        default: state <= XFER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// W25Q16BV read-command sequencer: owns chip select, issues opcode + 24-bit address and
// streams len data bytes out over valid/ready. SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B + dummy).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] CMD_READ = FLASH_CMD_READ,
  parameter int         CS_SETUP = 2,
  parameter int         CS_HOLD  = 2,
  parameter int         LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             flash_csx,
  output logic             spi_load,
  output logic [15:0]      spi_in,
  input  logic [15:0]      spi_out
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = FLASH_CMD_FAST_READ;
`else
  localparam logic [7:0] OPCODE = CMD_READ;
`endif

  flash_state_t     state;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       cnt;
  logic [1:0]       idx;
  logic             issued;
  logic             go;
  logic [7:0]       tx_byte;
  logic             xfer_done;
  logic [7:0]       rx_byte;

  spi_byte_xfer u_xfer (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .byte_in   (tx_byte),
    .spi_out   (spi_out),
    .spi_load  (spi_load),
    .spi_in    (spi_in),
    .xfer_done (xfer_done),
    .rx_byte   (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      flash_csx  <= 1'b1;
      addr_q     <= '0;
      remaining  <= '0;
      cnt        <= '0;
      idx        <= '0;
      issued     <= 1'b0;
      go         <= 1'b0;
      tx_byte    <= '0;
    end else begin
      go   <= 1'b0;
      done <= 1'b0;
      case (state)
        // busy is still high during the done cycle, which also blocks a start there
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            busy <= 1'b1;
            if (len != '0) begin
              addr_q    <= addr;
              remaining <= len;
              flash_csx <= 1'b0;
              cnt       <= '0;
              state     <= SETUP;
            end else begin
              done <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (cnt == 8'(CS_SETUP - 1)) begin
            issued <= 1'b0;
            state  <= CMD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        CMD: begin
          if (!issued) begin
            go      <= 1'b1;
            tx_byte <= OPCODE;
            issued  <= 1'b1;
          end else if (xfer_done) begin
            issued <= 1'b0;
            idx    <= 2'd0;
            state  <= ADDR;
          end
        end

        ADDR: begin
          if (!issued) begin
            go      <= 1'b1;
            tx_byte <= addr_byte(addr_q, idx);
            issued  <= 1'b1;
          end else if (xfer_done) begin
            issued <= 1'b0;
            if (idx == 2'd2) begin
`ifdef SPI_FLASH_FAST_READ_EN
              state <= DUMMY;
`else
              state <= DATA;
`endif
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

`ifdef SPI_FLASH_FAST_READ_EN
        DUMMY: begin
          if (!issued) begin
            go      <= 1'b1;
            tx_byte <= FLASH_DUMMY_BYTE;
            issued  <= 1'b1;
          end else if (xfer_done) begin
            issued <= 1'b0;
            state  <= DATA;
          end
        end
`endif

        // A held byte blocks the next load, so consumer backpressure simply stretches CSX low.
        DATA: begin
          if (data_valid) begin
            if (data_ready) begin
              data_valid <= 1'b0;
              remaining  <= remaining - 1'b1;
              if (remaining == LEN_W'(1)) begin
                cnt   <= '0;
                state <= HOLD;
              end
            end
          end else if (!issued) begin
            go      <= 1'b1;
            tx_byte <= FLASH_DUMMY_BYTE;
            issued  <= 1'b1;
          end else if (xfer_done) begin
            issued     <= 1'b0;
            data       <= rx_byte;
            data_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (cnt == 8'(CS_HOLD - 1)) begin
            flash_csx <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI byte controller plus W25Q16BV read model.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         HDR = 5;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         HDR = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, data_valid, flash_csx, spi_load;
  logic [7:0]  data;
  logic        data_ready = 1'b1;
  logic [15:0] spi_in;
  logic [15:0] spi_out = '0;

  int errors = 0;
  int checks = 0;

  int done_cnt = 0, busy_cyc = 0, load_cnt = 0, frames = 0;
  int load_err = 0, hold_err = 0, proto_err = 0;
  bit csx_prev = 1'b1;
  bit prev_valid = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] mosi[$];
  logic [7:0] beats[$];
  int rmode = 0;

  int ph = 0, dly = 0, fi = 0;
  bit sbusy = 1'b0;
  logic [7:0] rxb = '0, miso_next = '0;
  logic [23:0] fa = '0;
  int unsigned seed = 0;

  spi_flash_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .flash_csx  (flash_csx),
    .spi_load   (spi_load),
    .spi_in     (spi_in),
    .spi_out    (spi_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [20:0] a);
    logic [31:0] h;
    h = ({11'd0, a} * 32'h9E3779B1) ^ seed;
    return h[23:16] ^ h[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI controller: busy rises two cycles after the load, then a random byte time.
  always @(negedge clk) begin
    if (!reset_n) begin
      ph = 0; sbusy = 1'b0; dly = 0;
    end else if (spi_load) begin
      if (flash_csx || sbusy || ph != 0 || spi_in[15:8] != 8'h00) load_err++;
      ph = 1;
      dly = $urandom_range(3, 10);
      mosi.push_back(spi_in[7:0]);
      if (fi >= 1 && fi <= 3) fa = {fa[15:0], spi_in[7:0]};
      miso_next = (fi >= HDR) ? mem_byte(21'(fa + 24'(fi - HDR))) : 8'hFF;
      fi++;
    end else if (ph == 1) begin
      ph = 2;
    end else if (ph == 2) begin
      ph = 0; sbusy = 1'b1;
    end else if (sbusy) begin
      if (dly == 0) begin
        sbusy = 1'b0; rxb = miso_next;
      end else begin
        dly--;
      end
    end
    if (flash_csx) fi = 0;
    spi_out = {sbusy, 7'd0, rxb};
  end

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       data_ready = 1'b1;
      1:       data_ready = 1'($urandom_range(0, 1));
      default: data_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (data_valid && data_ready) beats.push_back(data);
    if (prev_valid && !prev_hs && reset_n && (!data_valid || data !== prev_data)) hold_err++;
    prev_valid = data_valid;
    prev_hs    = data_valid && data_ready;
    prev_data  = data;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (spi_load) load_cnt++;
    if (!flash_csx && csx_prev) frames++;
    csx_prev = flash_csx;
    if (done && (!busy || !flash_csx)) proto_err++;
  end

  task automatic wait_done(input int d0, input bit inject, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (inject && i == 20) begin
        start = 1'b1; addr = 24'hFFFFFF; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt != d0) got = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("%s_done_timeout", tag), 32'(got), 32'd1);
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [15:0] n, input int rm,
                         input bit inject, input string tag);
    logic [7:0] em[$];
    logic [7:0] ed[$];
    int d0, b0, f0, l0;
    em.push_back(OPC);
    em.push_back(a[23:16]);
    em.push_back(a[15:8]);
    em.push_back(a[7:0]);
`ifdef SPI_FLASH_FAST_READ_EN
    em.push_back(8'h00);
`endif
    for (int i = 0; i < int'(n); i++) begin
      em.push_back(8'h00);
      ed.push_back(mem_byte(21'(a + 24'(i))));
    end
    if (n == 0) em.delete();
    rmode = rm;
    mosi.delete();
    beats.delete();
    d0 = done_cnt; b0 = busy_cyc; f0 = frames; l0 = load_cnt;
    start = 1'b1; addr = a; len = n;
    @(negedge clk);
    start = 1'b0; addr = 24'($urandom); len = 16'($urandom);
    chk($sformatf("%s_busy_after_start", tag), 32'(busy), 32'd1);
    wait_done(d0, inject, tag);
    repeat (25) @(negedge clk);
    chk($sformatf("%s_mosi_count", tag), 32'(mosi.size()), 32'(em.size()));
    for (int i = 0; i < em.size() && mosi.size() == em.size(); i++)
      chk($sformatf("%s_mosi%0d", tag, i), 32'(mosi[i]), 32'(em[i]));
    chk($sformatf("%s_beat_count", tag), 32'(beats.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size() && beats.size() == ed.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(ed[i]));
    chk($sformatf("%s_done_pulses", tag), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("%s_csx_frames", tag), 32'(frames - f0), (n != 0) ? 32'd1 : 32'd0);
    chk($sformatf("%s_loads", tag), 32'(load_cnt - l0), 32'(em.size()));
    chk($sformatf("%s_csx_idle", tag), 32'(flash_csx), 32'd1);
    chk($sformatf("%s_busy_idle", tag), 32'(busy), 32'd0);
    if (n == 0) chk($sformatf("%s_busy_cycles", tag), 32'(busy_cyc - b0), 32'd1);
  endtask

  initial begin
    int d0, l0, bad;
    bit got;
    logic [23:0] ra;
    logic [7:0] hd;
    seed = $urandom;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_csx", 32'(flash_csx), 32'd1);
    chk("rst_load", 32'(spi_load), 32'd0);
    chk("rst_spi_in", 32'(spi_in), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(24'h012345, 16'd3, 0, 1'b0, "basic");
    run_txn(24'h000000, 16'd1, 0, 1'b0, "addr0");
    run_txn(24'h1FFFFE, 16'd3, 0, 1'b0, "wrap");
    run_txn(24'h0A0B0C, 16'd0, 0, 1'b0, "len0");

    // Backpressure: consumer stalls after the first beat.
    rmode = 2;
    ra = 24'($urandom);
    d0 = done_cnt;
    beats.delete();
    @(negedge clk);
    start = 1'b1; addr = ra; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (data_valid) got = 1'b1;
    end
    chk("bp_first_valid", 32'(got), 32'd1);
    chk("bp_first_data", 32'(data), 32'(mem_byte(21'(ra))));
    l0 = load_cnt; hd = data; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!data_valid || data !== hd || flash_csx || spi_load) bad++;
    end
    chk("bp_held", 32'(bad), 32'd0);
    chk("bp_no_load", 32'(load_cnt - l0), 32'd0);
    rmode = 0;
    wait_done(d0, 1'b0, "bp");
    repeat (5) @(negedge clk);
    chk("bp_beat_count", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) chk("bp_beat1", 32'(beats[1]), 32'(mem_byte(21'(ra + 24'd1))));

    run_txn(24'($urandom), 16'd4, 0, 1'b1, "ignore_start");

    // Reset while the second address byte is in flight.
    rmode = 0;
    mosi.delete();
    l0 = load_cnt;
    start = 1'b1; addr = 24'hABCDEF; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (load_cnt == l0 + 3) got = 1'b1;
    end
    chk("rst_mid_reach", 32'(got), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_csx", 32'(flash_csx), 32'd1);
    chk("rst_mid_load", 32'(spi_load), 32'd0);
    chk("rst_mid_valid", 32'(data_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_mosi", 32'(mosi.size()), 32'd3);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    run_txn(24'($urandom), 16'd2, 0, 1'b0, "post_rst");

    for (int k = 0; k < 4; k++)
      run_txn(24'($urandom), 16'($urandom_range(1, 5)), 1, 1'b0, $sformatf("rand%0d", k));

    chk("spi_load_legal", 32'(load_err), 32'd0);
    chk("data_hold", 32'(hold_err), 32'd0);
    chk("done_protocol", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
